// File: rtl/cache_pkg.sv
// Shared widths, address fields and FSM states for the direct-mapped write-back cache.
package cache_pkg;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_BLOCKS = 4;
  localparam int unsigned BLK_WORDS  = 4;
  localparam int unsigned CNT_W      = 16;

  localparam int unsigned BYTE_SEL_W = 2;
  localparam int unsigned IDX_W      = $clog2(NUM_BLOCKS);
  localparam int unsigned WORD_SEL_W = $clog2(BLK_WORDS);
  localparam int unsigned OFF_W      = WORD_SEL_W + BYTE_SEL_W;
  localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned BLK_W      = BLK_WORDS * WORD_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [IDX_W-1:0]      idx;
    logic [WORD_SEL_W-1:0] word;
    logic [BYTE_SEL_W-1:0] byte_sel;
  } addr_t;

  // Block-aligned byte address of a line
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/dirty/tag/data arrays: one combinational read port, one line or word-merge write port.
module cache_line_store
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid_c,
  output logic                  rd_dirty_c,
  output logic [TAG_W-1:0]      rd_tag_c,
  output logic [BLK_W-1:0]      rd_line_c,
  input  logic                  wr_en,
  input  logic                  wr_merge,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [BLK_W-1:0]      wr_line,
  input  logic [WORD_SEL_W-1:0] wr_sel,
  input  logic [WORD_W-1:0]     wr_word
);

  logic [NUM_BLOCKS-1:0]               valid_q;
  logic [NUM_BLOCKS-1:0]               dirty_q;
  logic [TAG_W-1:0]                    tag_q  [NUM_BLOCKS];
  logic [BLK_WORDS-1:0][WORD_W-1:0]    data_q [NUM_BLOCKS];

  assign rd_valid_c = valid_q[rd_idx];
  assign rd_dirty_c = dirty_q[rd_idx];
  assign rd_tag_c   = tag_q[rd_idx];
  assign rd_line_c  = data_q[rd_idx];

  // Line metadata; a merge marks the line dirty and keeps its tag, a refill installs it clean
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < int'(NUM_BLOCKS); i++) tag_q[i] <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_merge;
      if (!wr_merge) tag_q[wr_idx] <= wr_tag;
    end
  end

  // Data array carries no reset; its contents are meaningless until the line is valid
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_merge) data_q[wr_idx][wr_sel] <= wr_word;
      else          data_q[wr_idx]         <= wr_line;
    end
  end

endmodule

// File: rtl/cache_ctrl_wb.sv
// Sequencing controller for a 4-line, 4-word/line direct-mapped write-back, write-allocate cache.
module cache_ctrl_wb
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [WORD_W-1:0]   cpu_wdata,
  output logic [WORD_W-1:0]   cpu_rdata,
  output logic                cpu_ready,
  output logic                cpu_busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [BLK_W-1:0]    mem_wdata,
  input  logic [BLK_W-1:0]    mem_rdata,
  input  logic                mem_ready,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  state_t                          state;
  logic [TAG_W-1:0]                tag_q;
  logic [IDX_W-1:0]                idx_q;
  logic [WORD_SEL_W-1:0]           word_q;
  logic                            we_q;
  logic [WORD_W-1:0]               wdata_q;
  logic                            refilled_q;

  addr_t                           cpu_addr_c;
  logic                            unused_byte_c;
  logic                            line_valid_c;
  logic                            line_dirty_c;
  logic [TAG_W-1:0]                line_tag_c;
  logic [BLK_WORDS-1:0][WORD_W-1:0] line_c;
  logic                            hit_c;
  logic                            st_wr_en_c;
  logic                            st_wr_merge_c;

  assign cpu_addr_c    = addr_t'(cpu_addr);
  assign unused_byte_c = ^cpu_addr_c.byte_sel;
  assign hit_c         = line_valid_c && (line_tag_c == tag_q);

  // Store writes: word merge on a write hit, full line install when the refill returns
  always_comb begin
    st_wr_en_c    = 1'b0;
    st_wr_merge_c = 1'b0;
    if (state == COMPARE && hit_c && we_q) begin
      st_wr_en_c    = 1'b1;
      st_wr_merge_c = 1'b1;
    end else if (state == ALLOCATE && mem_req && mem_ready) begin
      st_wr_en_c    = 1'b1;
    end
  end

  cache_line_store u_store (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (idx_q),
    .rd_valid_c (line_valid_c),
    .rd_dirty_c (line_dirty_c),
    .rd_tag_c   (line_tag_c),
    .rd_line_c  (line_c),
    .wr_en      (st_wr_en_c),
    .wr_merge   (st_wr_merge_c),
    .wr_idx     (idx_q),
    .wr_tag     (tag_q),
    .wr_line    (mem_rdata),
    .wr_sel     (word_q),
    .wr_word    (wdata_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      refilled_q <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      cpu_busy   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            tag_q      <= cpu_addr_c.tag;
            idx_q      <= cpu_addr_c.idx;
            word_q     <= cpu_addr_c.word;
            we_q       <= cpu_we;
            wdata_q    <= cpu_wdata;
            refilled_q <= 1'b0;
            cpu_busy   <= 1'b1;
            state      <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit_c) begin
            if (!we_q) cpu_rdata <= line_c[word_q];
            cpu_ready <= 1'b1;
            cpu_busy  <= 1'b0;
            state     <= IDLE;
            // The re-compare after a refill completes the miss, not a new hit
            if (!refilled_q && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            mem_req <= 1'b1;
            if (line_valid_c && line_dirty_c) begin
              mem_we    <= 1'b1;
              mem_addr  <= blk_addr(line_tag_c, idx_q);
              mem_wdata <= line_c;
              state     <= WRITEBACK;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= blk_addr(tag_q, idx_q);
              state     <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          // Drop the request for one cycle so each block transfer is a distinct handshake
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= blk_addr(tag_q, idx_q);
          end else if (mem_ready) begin
            mem_req    <= 1'b0;
            refilled_q <= 1'b1;
            state      <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Scoreboard bench for cache_ctrl_wb: cache/memory reference model, randomized memory timing.
`timescale 1ns/1ps
module tb_cache_ctrl_wb;
  import cache_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [9:0]    cpu_addr;
  logic [31:0]   cpu_wdata, cpu_rdata;
  logic          cpu_ready, cpu_busy;
  logic          mem_req, mem_we;
  logic [9:0]    mem_addr;
  logic [127:0]  mem_wdata, mem_rdata;
  logic          mem_ready;
  logic [15:0]   hit_count, miss_count;

  always #5 clk = ~clk;

  cache_ctrl_wb dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: main memory as 64 blocks, cache as plain per-line arrays
  logic [127:0] mem [64];
  bit           ref_v [4];
  bit           ref_d [4];
  int           ref_tag [4];
  logic [31:0]  ref_data [4][4];
  int unsigned  ref_hits, ref_misses;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    bit          miss;
    bit          dirty;
    int unsigned acc;
    int unsigned hits;
    int unsigned misses;
  } exp_t;
  typedef struct {
    bit           we;
    logic [9:0]   addr;
    logic [127:0] wdata;
  } mexp_t;

  exp_t  exp_q [$];
  mexp_t mem_q [$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ref_v[i] = 0; ref_d[i] = 0; ref_tag[i] = 0;
    end
    ref_hits = 0; ref_misses = 0;
  endtask

  task automatic predict(input bit we, input logic [9:0] addr, input logic [31:0] wd, output exp_t e);
    int a, tag, idx, w;
    logic [127:0] line;
    mexp_t m;
    a = int'(addr); tag = a / 64; idx = (a / 16) % 4; w = (a / 4) % 4;
    e.miss  = !(ref_v[idx] && ref_tag[idx] == tag);
    e.dirty = 0;
    if (e.miss) begin
      if (ref_misses != 32'hFFFF) ref_misses++;
      if (ref_v[idx] && ref_d[idx]) begin
        e.dirty = 1;
        for (int k = 0; k < 4; k++) line[32*k +: 32] = ref_data[idx][k];
        m.we = 1; m.addr = 10'(ref_tag[idx] * 64 + idx * 16); m.wdata = line;
        mem_q.push_back(m);
        mem[ref_tag[idx] * 4 + idx] = line;
      end
      m.we = 0; m.addr = 10'(tag * 64 + idx * 16); m.wdata = '0;
      mem_q.push_back(m);
      line = mem[tag * 4 + idx];
      for (int k = 0; k < 4; k++) ref_data[idx][k] = line[32*k +: 32];
      ref_v[idx] = 1; ref_d[idx] = 0; ref_tag[idx] = tag;
    end else begin
      if (ref_hits != 32'hFFFF) ref_hits++;
    end
    if (we) begin
      ref_data[idx][w] = wd;
      ref_d[idx] = 1;
    end
    e.is_read = !we;
    e.rdata   = ref_data[idx][w];
    e.hits    = ref_hits;
    e.misses  = ref_misses;
  endtask

  // Memory responder: checks each request against the model, holds it for a chosen delay
  int           mem_delay = -1;
  bit           m_active, spur, m_stable;
  int           m_cnt, m_target;
  logic         m_we;
  logic [9:0]   m_addr;
  logic [127:0] m_wdata;
  int unsigned  lat_wb = 0, lat_al = 0;

  initial begin
    mexp_t mq;
    mem_ready = 1'b0; mem_rdata = '0; m_active = 0; spur = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ready = 1'b0; m_active = 0; spur = 0;
      end else begin
        if (m_active && mem_ready) begin
          mem_ready = 1'b0; m_active = 0;
          check("mem_req_stable", 128'(m_stable), 128'(1));
          if (m_we) lat_wb = m_cnt; else lat_al = m_cnt;
        end else if (spur) begin
          mem_ready = 1'b0; spur = 0;
        end
        if (m_active) begin
          if (!(mem_req && mem_we == m_we && mem_addr == m_addr && (!m_we || mem_wdata == m_wdata)))
            m_stable = 0;
          m_cnt++;
          if (m_cnt > m_target) begin
            mem_ready = 1'b1;
            if (!m_we) mem_rdata = mem[m_addr[9:4]];
          end
        end else if (mem_req) begin
          m_active = 1; m_stable = 1; m_cnt = 1;
          m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
          m_target = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, 4));
          if (mem_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_mem_req: got addr %0h we %0b, want no request", mem_addr, mem_we);
          end else begin
            mq = mem_q.pop_front();
            check("mem_we", 128'(mem_we), 128'(mq.we));
            check("mem_addr", 128'(mem_addr), 128'(mq.addr));
            if (mq.we) check("wb_data", mem_wdata, mq.wdata);
          end
          if (m_target == 0) begin
            mem_ready = 1'b1;
            if (!m_we) mem_rdata = mem[m_addr[9:4]];
          end
        end else if ($urandom_range(0, 7) == 0) begin
          mem_ready = 1'b1; spur = 1;
          mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
    end
  end

  // Monitor: every cpu_ready retires exactly one expected transaction
  always @(negedge clk) begin
    if (!reset && cpu_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_cpu_ready: got ready=1, want no completion (t=%0t)", $time);
      end else begin
        exp_t e;
        int unsigned want_lat;
        e = exp_q.pop_front();
        want_lat = !e.miss ? 2 : (e.dirty ? lat_wb + lat_al + 4 : lat_al + 3);
        if (e.is_read) check("cpu_rdata", 128'(cpu_rdata), 128'(e.rdata));
        check("latency", 128'(cyc - e.acc + 1), 128'(want_lat));
        check("hit_count", 128'(hit_count), 128'(e.hits));
        check("miss_count", 128'(miss_count), 128'(e.misses));
        check("busy_at_ready", 128'(cpu_busy), 128'(0));
        check("mem_ops_done", 128'(mem_q.size()), 128'(0));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    exp_q.delete(); mem_q.delete();
    model_reset();
  endtask

  task automatic issue(input bit we, input logic [9:0] addr, input logic [31:0] wd, input bit garbage);
    exp_t e;
    bit done;
    done = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    predict(we, addr, wd, e);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    check("busy_after_accept", 128'(cpu_busy), 128'(1));
    for (int i = 0; i < 300 && !done; i++) begin
      if (cpu_ready) done = 1;
      else begin
        if (garbage) begin
          cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = 10'($urandom()); cpu_wdata = $urandom();
        end
        @(negedge clk);
      end
    end
    cpu_req = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL cpu_ready_timeout: got no ready for addr %0h, want completion", addr);
      do_reset();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] saved;
    bit           found;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; reset = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    mem[0] = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", 128'(cpu_ready), 128'(0));
    check("rst_cpu_busy", 128'(cpu_busy), 128'(0));
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_cpu_rdata", 128'(cpu_rdata), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", mem_wdata, 128'(0));
    check("rst_counts", 128'({hit_count, miss_count}), 128'(0));
    #1 reset = 1'b0;

    // Cold miss, neighbouring hit, write hit, dirty eviction
    issue(0, 10'h000, 32'h0, 0);
    issue(0, 10'h004, 32'h0, 0);
    issue(1, 10'h008, 32'hDEADBEEF, 0);
    issue(0, 10'h040, 32'h0, 0);

    // Slow memory on a dirty miss while the CPU side toggles its request
    issue(1, 10'h040, 32'hCAFE0001, 0);
    mem_delay = 7;
    issue(0, 10'h100, 32'h0, 1);
    mem_delay = -1;

    // Reset while the victim write-back is outstanding
    issue(1, 10'h104, 32'h0BAD0104, 0);
    saved = mem[16];
    @(negedge clk);
    begin
      exp_t e;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h000;
      predict(0, 10'h000, 32'h0, e);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req && mem_we) found = 1;
      else @(negedge clk);
    end
    check("wb_reached", 128'(found), 128'(1));
    #2 reset = 1'b1;
    #1;
    check("abort_mem_req", 128'(mem_req), 128'(0));
    check("abort_cpu_busy", 128'(cpu_busy), 128'(0));
    exp_q.delete(); mem_q.delete();
    model_reset();
    mem[16] = saved;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_ready", 128'(cpu_ready), 128'(0));
    end
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(0, 10'h000, 32'h0, 0);

    // Write-allocate miss, then evict it to expose the merged dirty word
    issue(1, 10'h0B4, 32'h12345678, 0);
    issue(0, 10'h0F0, 32'h0, 0);

    // Randomized mix biased towards a few tags so hits, clean and dirty misses all occur
    for (int n = 0; n < 300; n++) begin
      logic [9:0] a;
      a = {($urandom_range(0, 5) == 0) ? 4'($urandom()) : 4'($urandom_range(0, 2)),
           2'($urandom()), 2'($urandom()), 2'($urandom())};
      issue(1'($urandom_range(0, 1)), a, $urandom(), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
